// File: rtl/hyperram_pkg.sv
// Shared types and constants for the hyperRAM request arbiter and its tag FIFO.
package hyperram_pkg;

    localparam int unsigned ADR_W   = 23;
    localparam int unsigned LEN_W   = 11;
    localparam int unsigned MAX_LEN = 1280;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned TAG_W   = IDX_W + 1;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [LEN_W-1:0] len;
        logic             rw;
    } hr_req_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             rw;
    } tag_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap
    } arb_state_e;

endpackage

// File: rtl/hr_tag_fifo.sv
// Ownership FIFO: one tag per queued transfer, popped in issue order on completion.
module hr_tag_fifo
    import hyperram_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_50,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [TAG_W-1:0] wdata_i,
    output logic [TAG_W-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    tag_t            mem_q [DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is allowed when a pop frees a slot in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= next_ptr(wptr_q);
            if (do_pop)  rptr_q <= next_ptr(rptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
            else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_50) begin
        if (do_push) mem_q[wptr_q] <= tag_t'(wdata_i);
    end

endmodule

// File: rtl/hyperram_req_arbiter.sv
// Round-robin arbiter feeding the hyperRAM controller queue, with strobe spacing,
// outstanding-transfer throttling and per-requester completion pulses.
module hyperram_req_arbiter
    import hyperram_pkg::*;
#(
    parameter int unsigned N_REQ           = 3,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned MAX_LEN         = hyperram_pkg::MAX_LEN,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic                   clk_50,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*ADR_W-1:0] req_addr,
    input  logic [N_REQ*LEN_W-1:0] req_len,
    input  logic [N_REQ-1:0]       req_rw,
    output logic [ADR_W-1:0]       q_adr,
    output logic [LEN_W-1:0]       q_len,
    output logic                   q_rw,
    output logic                   q_stb,
    input  logic                   xfer_done_async,
    output logic [N_REQ-1:0]       done_pulse,
    output logic [N_REQ-1:0]       err_len,
    output logic                   err_spurious,
    output logic [6:0]             outstanding,
    output logic                   busy
);

    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             legal_q, legal_d;
    hr_req_t          q_req_q, q_req_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [2:0]       sync_q;
    logic [N_REQ-1:0] done_q, done_d;
    logic             spur_q, spur_d;

    logic [IDX_W-1:0] grant_idx, hi_idx, lo_idx;
    logic             hi_found;
    hr_req_t          sel_req;
    logic             sel_legal;
    logic             done_edge, tag_push, tag_pop, tag_empty, tag_full;
    logic [TAG_W-1:0] tag_rdata;
    tag_t             tag_head;
    logic             unused_head_rw;

    // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = IDX_W'(i);
                if (i > int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_req.adr = req_addr[i*ADR_W +: ADR_W];
                sel_req.len = req_len[i*LEN_W +: LEN_W];
                sel_req.rw  = req_rw[i];
            end
        end
    end

    assign sel_legal = (sel_req.len != '0) && (32'(sel_req.len) <= MAX_LEN);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        legal_d   = legal_q;
        q_req_d   = q_req_q;
        gap_d     = gap_q;
        tag_push  = 1'b0;
        q_stb     = 1'b0;
        req_ready = '0;
        err_len   = '0;
        case (state_q)
            StIdle: begin
                if (|req_valid && (cnt_q < 7'(MAX_OUTSTANDING)) && !tag_full) begin
                    state_d = StIssue;
                    ptr_d   = grant_idx;
                    idx_d   = grant_idx;
                    legal_d = sel_legal;
                    // Queue-side fields only move on a real strobe so they hold between strobes.
                    if (sel_legal) q_req_d = sel_req;
                end
            end
            StIssue: begin
                req_ready = N_REQ'(1) << idx_q;
                if (legal_q) begin
                    q_stb    = 1'b1;
                    tag_push = 1'b1;
                end else begin
                    err_len = N_REQ'(1) << idx_q;
                end
                gap_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) state_d = StIdle;
                else                                gap_d   = gap_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    assign done_edge = sync_q[1] && !sync_q[2];
    assign tag_pop   = done_edge && !tag_empty;
    assign tag_head  = tag_t'(tag_rdata);
    assign unused_head_rw = tag_head.rw;

    always_comb begin
        cnt_d  = cnt_q + {6'b0, tag_push} - {6'b0, tag_pop};
        spur_d = spur_q || (done_edge && tag_empty);
        done_d = tag_pop ? (N_REQ'(1) << tag_head.idx) : '0;
    end

    always_ff @(posedge clk_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            ptr_q   <= IDX_W'(N_REQ - 1);
            idx_q   <= '0;
            legal_q <= 1'b0;
            q_req_q <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            sync_q  <= '0;
            done_q  <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            legal_q <= legal_d;
            q_req_q <= q_req_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[1:0], xfer_done_async};
            done_q  <= done_d;
            spur_q  <= spur_d;
        end
    end

    hr_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk_50  (clk_50),
        .resetn  (resetn),
        .push_i  (tag_push),
        .pop_i   (tag_pop),
        .wdata_i ({idx_q, q_req_q.rw}),
        .rdata_o (tag_rdata),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    assign q_adr        = q_req_q.adr;
    assign q_len        = q_req_q.len;
    assign q_rw         = q_req_q.rw;
    assign done_pulse   = done_q;
    assign err_spurious = spur_q;
    assign outstanding  = cnt_q;
    assign busy         = (cnt_q != '0) || (state_q != StIdle);

endmodule

// File: doc/hyperram_req_arbiter.md
Name: hyperram_req_arbiter

Overview:
- Shares the hyperRAM controller's transaction queue among N_REQ requesters, e.g. Ethernet RX frame writer, TX frame reader and housekeeping.
- Arbitrates round-robin and validates length.
- Drives the controller queue strobe with the spacing the queue FIFO write logic requires.
- Throttles outstanding transactions and returns a per-requester completion pulse by tracking ownership of each queued transfer.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MAX_OUTSTANDING, 8, max queued-but-unfinished transactions (1..63; must be below the controller queue depth).
- MAX_LEN, 1280, largest legal transfer length in bytes.
- GAP_CYCLES, 2, idle clk_50 cycles forced after each queue strobe (>=1).

Ports:
- clk_50  in  1  system clock, same clock as the controller queue interface.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  request pending, one bit per requester.
- req_ready  out  N_REQ  one-cycle accept pulse per requester.
- req_addr  in  N_REQ*23  word address, requester i at [23i+22:23i].
- req_len  in  N_REQ*11  transfer length in bytes, requester i at [11i+10:11i].
- req_rw  in  N_REQ  1 = read RAM, 0 = write RAM.
- q_adr  out  23  address to controller queue.
- q_len  out  11  length to controller queue.
- q_rw  out  1  rw flag to controller queue.
- q_stb  out  1  one-cycle queue write strobe (controller clockQueury).
- xfer_done_async  in  1  controller end-of-transfer flag, from the driver clock domain.
- done_pulse  out  N_REQ  one-cycle completion pulse to the owning requester.
- err_len  out  N_REQ  one-cycle pulse: request rejected for illegal length.
- err_spurious  out  1  sticky: completion seen with nothing outstanding.
- outstanding  out  7  current count of queued-but-unfinished transactions.
- busy  out  1  outstanding != 0 or FSM not in IDLE.

Behaviour:
- Reset (resetn low, async):
  - FSM to IDLE; all outputs 0; tag FIFO empty.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - Done synchronizer flops cleared.
- FSM states: IDLE, ISSUE, GAP.
- IDLE:
  - Eligible only when outstanding < MAX_OUTSTANDING.
  - Grant the first i with req_valid[i], searching from pointer+1 modulo N_REQ.
  - Latch index, addr, len and rw into registers; pointer <= i; go to ISSUE next edge.
  - With no valid request or a full count, stay in IDLE.
- ISSUE (exactly 1 cycle), legal length (1..MAX_LEN):
  - q_adr, q_len, q_rw driven from the latched registers; q_stb = 1; req_ready[i] = 1.
  - outstanding increments; tag FIFO pushes {i, rw}; go to GAP.
- ISSUE, illegal length (0 or > MAX_LEN):
  - req_ready[i] = 1 and err_len[i] = 1; no q_stb; count and tag FIFO unchanged; go to GAP.
- Requester rule: req_valid and the request fields must stay stable from assertion until its req_ready pulse. Fields are sampled in the IDLE grant cycle.
- GAP:
  - GAP_CYCLES cycles with q_stb = 0, then IDLE.
  - Minimum strobe period is therefore GAP_CYCLES+2 cycles (4 at default).
- q_adr, q_len and q_rw hold their last values between strobes.
- Done path:
  - xfer_done_async passes through a 2-flop synchronizer, then rising-edge detect. The edge is seen 3 clk_50 cycles after the input rises.
  - On the edge: pop tag FIFO; done_pulse[tag.idx] = 1 for 1 cycle; outstanding decrements.
  - Edge with outstanding == 0: no pop, no pulse; err_spurious set until reset.
- Increment and decrement in the same cycle: outstanding unchanged; push and pop both occur.
- Completions are in issue order; the controller queue is FIFO.
- Outstanding saturates at neither end. Overflow is impossible by the eligibility rule; underflow is blocked by the spurious check.
- Reset mid-operation: in-flight requests are dropped and requesters must re-present. Controller-side recovery is out of scope.

Decomposition:
- Shared package hyperram_pkg holds:
  - ADR_W = 23, LEN_W = 11, MAX_LEN = 1280.
  - typedef hr_req_t {adr, len, rw}.
  - typedef tag_t {idx, rw}.
  - FSM state enum.
- One sub-module, hr_tag_fifo: synchronous FIFO of tag_t, depth MAX_OUTSTANDING, push/pop/empty/full, same clk_50 and resetn.

Test Plan:
- Single requester: req 1 writes addr 0x000100, len 64 -> q_stb 1 cycle after grant with q_adr 0x000100, q_len 64, q_rw 0; req_ready[1] on the same cycle; outstanding = 1; after the xfer_done_async edge, done_pulse[1] 3 cycles later and outstanding = 0.
- All three requesters valid continuously -> strobe order 0,1,2,0,1,2; strobes exactly 4 cycles apart.
- Nine back-to-back requests with no completions -> 8 strobes, then IDLE stalls with outstanding = 8. One done -> 9th strobe issues.
- len = 0 and len = 1281 -> req_ready and err_len pulses; no q_stb; outstanding unchanged. len = 1280 is accepted.
- Done edge in the same cycle as a strobe with outstanding = 3 -> outstanding stays 3; done_pulse goes to the oldest tag's requester.
- Done edge with outstanding = 0 -> err_spurious = 1 and stays set. resetn low mid-GAP -> all outputs 0 asynchronously; requester 0 is granted first after release.
